// File: rtl/key_filter_multi.sv
// ---------------------------------------------------------------------------
// key_filter_multi
//
// Multi-channel push-button debouncer. Each of KEY_NUM active-low raw key
// inputs passes through its own 2-FF synchroniser, debounce FSM and debounce
// counter. Channels are fully independent of each other.
//
// Optional feature macro: KEY_LONG_PRESS_EN
//   defined   : a per-channel hold counter produces a one-cycle key_long
//               pulse LONG_MAX cycles after the debounced press.
//   undefined : no hold counter is built; key_long is tied to 0.
//
// Parameters:
//   CLK_FREQ   - clock frequency in Hz
//   SHAKE_FREQ - inverse of the debounce window in Hz
//   KEY_NUM    - number of channels (1..16)
//   LONG_MS    - long-press hold time in ms (long-press build only)
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   key_in      - raw asynchronous keys, 0 = pressed
//   key_level   - debounced state, 1 = pressed
//   key_press   - one-cycle pulse on debounced press
//   key_release - one-cycle pulse on debounced release
//   key_long    - one-cycle pulse on long press (0 without the macro)
//
// All outputs are registered. A press or release is reported 3+CNT_MAX
// cycles after the new input level is first sampled.
// ---------------------------------------------------------------------------
module key_filter_multi #(
    parameter int CLK_FREQ   = 50000000,
    parameter int SHAKE_FREQ = 100,
    parameter int KEY_NUM    = 4,
    parameter int LONG_MS    = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_level,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    localparam int CNT_MAX = CLK_FREQ / SHAKE_FREQ - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    // One-hot state encoding
    localparam logic [3:0] S_IDLE       = 4'b0001;
    localparam logic [3:0] S_PRESS_FILT = 4'b0010;
    localparam logic [3:0] S_PRESSED    = 4'b0100;
    localparam logic [3:0] S_REL_FILT   = 4'b1000;

`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_MAX = CLK_FREQ / 1000 * LONG_MS - 1;
    localparam int LONG_W   = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
    localparam logic [LONG_W-1:0] LONG_TOP = LONG_W'(LONG_MAX);
`endif

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_ch

        logic             d0_q;
        logic             d1_q;
        logic [3:0]       state_q;
        logic [3:0]       state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             level_q;
        logic             level_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;

        // Synchroniser; both stages reset to "released" so leaving reset
        // never looks like a key press.
        always_ff @(posedge clk) begin
            if (rst) begin
                d0_q <= 1'b1;
                d1_q <= 1'b1;
            end else begin
                d0_q <= key_in[k];
                d1_q <= d0_q;
            end
        end

        // State register, debounce counter and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        // Next-state logic
        always_comb begin
            state_d = S_IDLE;
            case (state_q)
                S_IDLE: begin
                    state_d = d1_q ? S_IDLE : S_PRESS_FILT;
                end
                S_PRESS_FILT: begin
                    if (d1_q)
                        state_d = S_IDLE;
                    else if (cnt_q == CNT_TOP)
                        state_d = S_PRESSED;
                    else
                        state_d = S_PRESS_FILT;
                end
                S_PRESSED: begin
                    state_d = d1_q ? S_REL_FILT : S_PRESSED;
                end
                S_REL_FILT: begin
                    if (!d1_q)
                        state_d = S_PRESSED;
                    else if (cnt_q == CNT_TOP)
                        state_d = S_IDLE;
                    else
                        state_d = S_REL_FILT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Output / counter next-value logic. Outputs are computed from the
        // upcoming state so that they change on the same edge as the state.
        always_comb begin
            cnt_d     = '0;
            level_d   = (state_d == S_PRESSED) || (state_d == S_REL_FILT);
            // Only a completed press filter yields a press pulse; a release
            // bounce returning to PRESSED stays silent.
            press_d   = (state_q == S_PRESS_FILT) && (state_d == S_PRESSED);
            release_d = (state_q == S_REL_FILT) && (state_d == S_IDLE);
            if ((state_d == state_q) &&
                ((state_q == S_PRESS_FILT) || (state_q == S_REL_FILT))) begin
                // Holding at the top is unreachable (the filter exits there)
                // but keeps the counter from ever wrapping.
                cnt_d = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + 1'b1;
            end
        end

        assign key_level[k]   = level_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;

`ifdef KEY_LONG_PRESS_EN
        logic              held;
        logic [LONG_W-1:0] long_cnt_q;
        logic [LONG_W-1:0] long_cnt_d;
        logic              long_q;
        logic              long_d;

        // REL_FILT counts as held so a release bounce does not restart the
        // hold timer.
        assign held = (state_q == S_PRESSED) || (state_q == S_REL_FILT);

        always_ff @(posedge clk) begin
            if (rst) begin
                long_cnt_q <= '0;
                long_q     <= 1'b0;
            end else begin
                long_cnt_q <= long_cnt_d;
                long_q     <= long_d;
            end
        end

        // Saturating hold counter; the pulse fires only on the step onto
        // the top value, giving at most one pulse per press.
        always_comb begin
            long_cnt_d = '0;
            long_d     = 1'b0;
            if (held) begin
                if (long_cnt_q != LONG_TOP) begin
                    long_cnt_d = long_cnt_q + 1'b1;
                    long_d     = (long_cnt_d == LONG_TOP);
                end else begin
                    long_cnt_d = long_cnt_q;
                end
            end
        end

        assign key_long[k] = long_q;
`else
        assign key_long[k] = 1'b0;
`endif

    end : g_ch

endmodule
